ai_cu_layer_scheduler: RTL and testbench

Parametrised multi-layer control unit for the AI accelerator, the successor to the single-descriptor decode/FSM pair. It queues layer descriptors in a FIFO and runs each layer through fetch/compute/writeback phases against the memory and sequencer handshakes. Activation buffers ping-pong between two base addresses. A chain of layers therefore runs back-to-back without host intervention between layers.

---
 rtl/ai_cu_pkg.sv | 30 +++
 rtl/ai_cu_desc_fifo.sv | 57 +++++
 rtl/ai_cu_layer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ai_cu_layer_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_cu_pkg.sv
// Shared types and constants for the AI accelerator layer scheduler:
// FSM states, layer-type codes and descriptor instruction bit offsets.
package ai_cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_FETCH,
        S_COMPUTE,
        S_WRITEBACK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int LT_CONV = 0;
    localparam int LT_FC   = 1;
    localparam int LT_POOL = 2;
    localparam int LT_COPY = 3;

    localparam int TYPE_LSB   = 0;
    localparam int KERNEL_LSB = 4;
    localparam int STRIDE_LSB = 8;
    localparam int RELU_BIT   = 12;
    localparam int POOL_BIT   = 13;
    localparam int LAST_BIT   = 14;

    // Only the defined instruction bits travel through the descriptor queue.
    localparam int DESC_BITS = LAST_BIT + 1;

endpackage

// File: rtl/ai_cu_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count and a flush that empties
// it in one cycle. Push while full and pop while empty are ignored.
module ai_cu_desc_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are valid, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ai_cu_layer_scheduler.sv
// Multi-layer control unit: queues layer descriptors and runs each through
// fetch/compute/writeback, ping-ponging activations between two buffers.
module ai_cu_layer_scheduler
    import ai_cu_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int DEPTH      = 8,
    parameter int TYPE_WIDTH = 4,
    parameter int K_WIDTH    = 4,
    parameter int S_WIDTH    = 4,
    parameter int NUM_TYPES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [INST_WIDTH-1:0]      desc_inst,
    input  logic [LEN_W-1:0]           desc_ifm_len,
    input  logic [LEN_W-1:0]           desc_ofm_len,
    input  logic [ADDR_W-1:0]          buf_a_base,
    input  logic [ADDR_W-1:0]          buf_b_base,
    input  logic                       abort,
    input  logic                       err_clear,
    output logic                       mem_read_req,
    output logic [ADDR_W-1:0]          mem_read_addr,
    output logic [LEN_W-1:0]           mem_read_len,
    input  logic                       mem_read_done,
    output logic                       mem_write_req,
    output logic [ADDR_W-1:0]          mem_write_addr,
    output logic [LEN_W-1:0]           mem_write_len,
    input  logic                       mem_write_done,
    output logic                       seq_start,
    input  logic                       seq_done,
    output logic [TYPE_WIDTH-1:0]      layer_type,
    output logic [K_WIDTH-1:0]         kernel_size,
    output logic [S_WIDTH-1:0]         stride,
    output logic                       relu_en,
    output logic                       pool_en,
    output logic                       layer_done,
    output logic                       batch_done,
    output logic                       busy,
    output logic                       error,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int FIFO_W = DESC_BITS + 2 * LEN_W;

    state_t                state;
    logic                  src_b;
    logic                  last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_W-1:0]     fifo_dout;
    logic [DESC_BITS-1:0]  head_inst;
    logic [LEN_W-1:0]      head_ifm_len;
    logic [LEN_W-1:0]      head_ofm_len;
    logic [TYPE_WIDTH-1:0] head_type;
    logic                  unused_reserved;

    assign unused_reserved = ^desc_inst[INST_WIDTH-1:DESC_BITS];
    assign desc_ready      = !fifo_full;
    assign busy            = (state != S_IDLE);
    assign {head_inst, head_ifm_len, head_ofm_len} = fifo_dout;
    assign head_type       = head_inst[TYPE_LSB +: TYPE_WIDTH];

    ai_cu_desc_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (desc_valid && desc_ready),
        .din   ({desc_inst[DESC_BITS-1:0], desc_ifm_len, desc_ofm_len}),
        .pop   (state == S_DECODE),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            src_b          <= 1'b0;
            last           <= 1'b0;
            error          <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_read_addr  <= '0;
            mem_read_len   <= '0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_len  <= '0;
            seq_start      <= 1'b0;
            layer_type     <= '0;
            kernel_size    <= '0;
            stride         <= '0;
            relu_en        <= 1'b0;
            pool_en        <= 1'b0;
            layer_done     <= 1'b0;
            batch_done     <= 1'b0;
        end else if (abort) begin
            // Flush everything in flight; the queue is emptied by the FIFO itself.
            state         <= S_IDLE;
            src_b         <= 1'b0;
            error         <= 1'b0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            seq_start     <= 1'b0;
            layer_done    <= 1'b0;
            batch_done    <= 1'b0;
        end else begin
            seq_start  <= 1'b0;
            layer_done <= 1'b0;
            batch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_DECODE;
                end
                S_DECODE: begin
                    layer_type     <= head_type;
                    kernel_size    <= head_inst[KERNEL_LSB +: K_WIDTH];
                    stride         <= head_inst[STRIDE_LSB +: S_WIDTH];
                    relu_en        <= head_inst[RELU_BIT];
                    pool_en        <= head_inst[POOL_BIT];
                    last           <= head_inst[LAST_BIT];
                    mem_read_len   <= head_ifm_len;
                    mem_write_len  <= head_ofm_len;
                    mem_read_addr  <= src_b ? buf_b_base : buf_a_base;
                    mem_write_addr <= src_b ? buf_a_base : buf_b_base;
                    if (int'(head_type) >= NUM_TYPES) begin
                        error <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        mem_read_req <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_read_done) begin
                        mem_read_req <= 1'b0;
                        if (int'(layer_type) == LT_COPY) begin
                            mem_write_req <= 1'b1;
                            state         <= S_WRITEBACK;
                        end else begin
                            seq_start <= 1'b1;
                            state     <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (seq_done) begin
                        mem_write_req <= 1'b1;
                        state         <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_write_done) begin
                        mem_write_req <= 1'b0;
                        layer_done    <= 1'b1;
                        batch_done    <= last;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A finished batch restarts from buffer A; otherwise swap roles.
                    src_b <= last ? 1'b0 : !src_b;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    if (err_clear) begin
                        error <= 1'b0;
                        src_b <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_cu_layer_scheduler.sv
// Self-checking bench for ai_cu_layer_scheduler: descriptor table plus directed
// sequences, with a scoreboard of expected layer transactions.
module tb_ai_cu_layer_scheduler;
    import ai_cu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'h0000_2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          desc_valid;
    logic          desc_ready;
    logic [31:0]   desc_inst;
    logic [15:0]   desc_ifm_len;
    logic [15:0]   desc_ofm_len;
    logic [31:0]   buf_a_base;
    logic [31:0]   buf_b_base;
    logic          abort;
    logic          err_clear;
    logic          mem_read_req;
    logic [31:0]   mem_read_addr;
    logic [15:0]   mem_read_len;
    logic          mem_read_done = 1'b0;
    logic          mem_write_req;
    logic [31:0]   mem_write_addr;
    logic [15:0]   mem_write_len;
    logic          mem_write_done = 1'b0;
    logic          seq_start;
    logic          seq_done = 1'b0;
    logic [3:0]    layer_type;
    logic [3:0]    kernel_size;
    logic [3:0]    stride;
    logic          relu_en;
    logic          pool_en;
    logic          layer_done;
    logic          batch_done;
    logic          busy;
    logic          error;
    logic [CW-1:0] fifo_count;

    ai_cu_layer_scheduler #(
        .INST_WIDTH (32),
        .ADDR_W     (32),
        .LEN_W      (16),
        .DEPTH      (DEPTH),
        .TYPE_WIDTH (4),
        .K_WIDTH    (4),
        .S_WIDTH    (4),
        .NUM_TYPES  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_inst      (desc_inst),
        .desc_ifm_len   (desc_ifm_len),
        .desc_ofm_len   (desc_ofm_len),
        .buf_a_base     (buf_a_base),
        .buf_b_base     (buf_b_base),
        .abort          (abort),
        .err_clear      (err_clear),
        .mem_read_req   (mem_read_req),
        .mem_read_addr  (mem_read_addr),
        .mem_read_len   (mem_read_len),
        .mem_read_done  (mem_read_done),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_len  (mem_write_len),
        .mem_write_done (mem_write_done),
        .seq_start      (seq_start),
        .seq_done       (seq_done),
        .layer_type     (layer_type),
        .kernel_size    (kernel_size),
        .stride         (stride),
        .relu_en        (relu_en),
        .pool_en        (pool_en),
        .layer_done     (layer_done),
        .batch_done     (batch_done),
        .busy           (busy),
        .error          (error),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd_addr;
        logic [15:0] rd_len;
        logic [31:0] wr_addr;
        logic [15:0] wr_len;
        int          seqs;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [15:0] ifm;
        logic [15:0] ofm;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        int          seqs;
        logic        last;
        int          cyc;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   rd_delay = 0;
    int   wr_delay = 0;
    int   sq_delay = 0;
    bit   rd_hold = 1'b0;
    bit   sq_hold = 1'b0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   sq_cnt = 0;
    bit   sq_run = 1'b0;
    int   seq_seen = 0;
    int   busy_cnt = 0;
    int   layers = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen that should not occur", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input int t, input int k, input int s,
                                            input bit relu, input bit pool, input bit last);
        logic [31:0] w;
        w        = 32'h00A5_8000;
        w[3:0]   = t[3:0];
        w[7:4]   = k[3:0];
        w[11:8]  = s[3:0];
        w[12]    = relu;
        w[13]    = pool;
        w[14]    = last;
        return w;
    endfunction

    task automatic expect_layer(input logic [31:0] rd_addr, input logic [15:0] rd_len,
                                input logic [31:0] wr_addr, input logic [15:0] wr_len,
                                input int seqs, input logic last, input int cyc);
        exp_t e;
        e.rd_addr = rd_addr;
        e.rd_len  = rd_len;
        e.wr_addr = wr_addr;
        e.wr_len  = wr_len;
        e.seqs    = seqs;
        e.last    = last;
        e.cyc     = cyc;
        exp_q.push_back(e);
    endtask

    task automatic push_desc(input logic [31:0] inst, input logic [15:0] ifm, input logic [15:0] ofm);
        desc_valid   = 1'b1;
        desc_inst    = inst;
        desc_ifm_len = ifm;
        desc_ofm_len = ofm;
        tick();
        desc_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((busy || fifo_count != '0 || exp_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, {62'd0, busy, exp_q.size() != 0}, 64'd0);
    endtask

    // Memory/sequencer responder and scoreboard monitor, both on the falling edge.
    always @(negedge clk) begin
        if (mem_read_req && !rd_hold) begin
            mem_read_done = (rd_cnt >= rd_delay);
            rd_cnt = mem_read_done ? 0 : rd_cnt + 1;
        end else begin
            mem_read_done = 1'b0;
            rd_cnt = 0;
        end
        if (mem_write_req) begin
            mem_write_done = (wr_cnt >= wr_delay);
            wr_cnt = mem_write_done ? 0 : wr_cnt + 1;
        end else begin
            mem_write_done = 1'b0;
            wr_cnt = 0;
        end
        if (seq_start) begin
            sq_run = 1'b1;
            sq_cnt = 0;
        end
        if (sq_run && !sq_hold) begin
            seq_done = (sq_cnt >= sq_delay);
            if (seq_done) sq_run = 1'b0;
            else sq_cnt++;
        end else begin
            seq_done = 1'b0;
        end

        if (abort) begin
            exp_q.delete();
            seq_seen = 0;
            sq_run   = 1'b0;
            seq_done = 1'b0;
        end else begin
            busy_cnt = busy ? busy_cnt + 1 : 0;
            seq_seen += int'(seq_start);
            if (mem_read_req && mem_read_done) begin
                if (exp_q.size() == 0) fail("read_unexpected");
                else begin
                    check("read_addr", mem_read_addr, exp_q[0].rd_addr);
                    check("read_len", mem_read_len, exp_q[0].rd_len);
                end
            end
            if (mem_write_req && mem_write_done) begin
                if (exp_q.size() == 0) fail("write_unexpected");
                else begin
                    check("write_addr", mem_write_addr, exp_q[0].wr_addr);
                    check("write_len", mem_write_len, exp_q[0].wr_len);
                end
            end
            if (layer_done) begin
                if (exp_q.size() == 0) fail("layer_done_unexpected");
                else begin
                    mon_e = exp_q.pop_front();
                    check("batch_done", batch_done, mon_e.last);
                    check("seq_starts", seq_seen, mon_e.seqs);
                    if (mon_e.cyc != 0) check("layer_cycles", busy_cnt, mon_e.cyc);
                end
                seq_seen = 0;
                layers++;
            end else if (batch_done) begin
                fail("batch_done_alone");
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   lb;

        vecs[0] = '{mk_inst(LT_CONV, 3, 1, 1'b1, 1'b0, 1'b0), 16'd100, 16'd50, BASE_A, BASE_B, 1, 1'b0, 5};
        vecs[1] = '{mk_inst(LT_FC,   1, 1, 1'b0, 1'b0, 1'b0), 16'd200, 16'd20, BASE_B, BASE_A, 1, 1'b0, 5};
        vecs[2] = '{mk_inst(LT_POOL, 2, 2, 1'b0, 1'b1, 1'b1), 16'd40,  16'd10, BASE_A, BASE_B, 1, 1'b1, 5};
        vecs[3] = '{mk_inst(LT_COPY, 1, 1, 1'b0, 0, 1'b1),    16'd77,  16'd78, BASE_A, BASE_B, 0, 1'b1, 4};

        rst          = 1'b0;
        desc_valid   = 1'b0;
        desc_inst    = '0;
        desc_ifm_len = '0;
        desc_ofm_len = '0;
        buf_a_base   = BASE_A;
        buf_b_base   = BASE_B;
        abort        = 1'b0;
        err_clear    = 1'b0;
        repeat (3) tick();

        check("rst_desc_ready", desc_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_read_req", mem_read_req, 0);
        check("rst_write_req", mem_write_req, 0);
        check("rst_seq_start", seq_start, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_read_addr", mem_read_addr, 0);
        check("rst_layer_type", layer_type, 0);
        rst = 1'b1;
        tick();

        // Single conv layer: latency from push and minimum 5-cycle layer.
        expect_layer(BASE_A, 16'd64, BASE_B, 16'd32, 1, 1'b1, 5);
        push_desc(mk_inst(LT_CONV, 3, 1, 1'b1, 1'b0, 1'b1), 16'd64, 16'd32);
        check("b_count_after_push", fifo_count, 1);
        check("b_idle_at_push", busy, 0);
        tick();
        check("b_busy_decode", busy, 1);
        check("b_no_req_decode", mem_read_req, 0);
        tick();
        check("b_read_req", mem_read_req, 1);
        check("b_read_addr", mem_read_addr, BASE_A);
        check("b_read_len", mem_read_len, 64);
        check("b_popped", fifo_count, 0);
        check("b_kernel", kernel_size, 3);
        check("b_stride", stride, 1);
        check("b_relu", relu_en, 1);
        check("b_pool", pool_en, 0);
        wait_idle(30, "b_idle");

        // Table: conv/fc/pool chain with last on the pool, then a copy layer.
        for (int i = 0; i < 4; i++) begin
            expect_layer(vecs[i].rd_addr, vecs[i].ifm, vecs[i].wr_addr, vecs[i].ofm,
                         vecs[i].seqs, vecs[i].last, vecs[i].cyc);
            push_desc(vecs[i].inst, vecs[i].ifm, vecs[i].ofm);
        end
        wait_idle(100, "c_idle");
        check("c_copy_type_held", layer_type, LT_COPY);

        // Fill the queue behind a layer stalled in FETCH; the ninth push is dropped.
        rd_delay = 1;
        wr_delay = 2;
        sq_delay = 1;
        rd_hold  = 1'b1;
        lb       = layers;
        expect_layer(BASE_A, 16'd300, BASE_B, 16'd310, 1, 1'b0, 0);
        push_desc(mk_inst(LT_CONV, 1, 1, 1'b0, 1'b0, 1'b0), 16'd300, 16'd310);
        n = 0;
        while (!mem_read_req && n < 20) begin
            tick();
            n++;
        end
        check("d_stall_fetch", mem_read_req, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) check("d_ready_before_8th", desc_ready, 1);
            expect_layer((k % 2 == 1) ? BASE_B : BASE_A, 16'(300 + k),
                         (k % 2 == 1) ? BASE_A : BASE_B, 16'(310 + k), 1, k == 8, 0);
            push_desc(mk_inst(LT_FC, 1, 1, 1'b0, 1'b0, k == 8), 16'(300 + k), 16'(310 + k));
        end
        check("d_count_full", fifo_count, 8);
        check("d_ready_full", desc_ready, 0);
        push_desc(mk_inst(LT_CONV, 1, 1, 1'b0, 1'b0, 1'b1), 16'd999, 16'd999);
        check("d_count_after_drop", fifo_count, 8);
        check("d_ready_after_drop", desc_ready, 0);
        rd_hold = 1'b0;
        wait_idle(500, "d_idle");
        check("d_layer_count", layers - lb, 9);
        rd_delay = 0;
        wr_delay = 0;
        sq_delay = 0;

        // Illegal type: error, no requests, queue held until err_clear.
        expect_layer(BASE_A, 16'd64, BASE_B, 16'd64, 1, 1'b0, 5);
        push_desc(mk_inst(LT_CONV, 3, 1, 1'b0, 1'b0, 1'b0), 16'd64, 16'd64);
        push_desc(mk_inst(7, 3, 1, 1'b0, 1'b0, 1'b0), 16'd500, 16'd501);
        expect_layer(BASE_A, 16'd65, BASE_B, 16'd66, 1, 1'b1, 5);
        push_desc(mk_inst(LT_CONV, 5, 2, 1'b1, 1'b0, 1'b1), 16'd65, 16'd66);
        n = 0;
        while (!error && n < 50) begin
            tick();
            n++;
        end
        check("f_error_set", error, 1);
        check("f_type_held", layer_type, 7);
        check("f_busy", busy, 1);
        check("f_no_read", mem_read_req, 0);
        check("f_no_write", mem_write_req, 0);
        check("f_queue_held", fifo_count, 1);
        repeat (3) tick();
        check("f_error_sticky", error, 1);
        check("f_queue_still_held", fifo_count, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("f_error_cleared", error, 0);
        check("f_idle_after_clear", busy, 0);
        wait_idle(50, "f_idle");

        // Abort mid-compute with two entries queued.
        expect_layer(BASE_A, 16'd70, BASE_B, 16'd71, 1, 1'b0, 5);
        push_desc(mk_inst(LT_CONV, 3, 1, 1'b0, 1'b0, 1'b0), 16'd70, 16'd71);
        wait_idle(30, "g_first_idle");
        sq_hold = 1'b1;
        expect_layer(BASE_B, 16'd80, BASE_A, 16'd81, 1, 1'b0, 0);
        push_desc(mk_inst(LT_CONV, 3, 1, 1'b0, 1'b0, 1'b0), 16'd80, 16'd81);
        n = 0;
        while (!seq_start && n < 20) begin
            tick();
            n++;
        end
        check("g_in_compute", seq_start, 1);
        push_desc(mk_inst(LT_FC, 1, 1, 1'b0, 1'b0, 1'b0), 16'd82, 16'd83);
        push_desc(mk_inst(LT_FC, 1, 1, 1'b0, 1'b0, 1'b1), 16'd84, 16'd85);
        check("g_queued", fifo_count, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("g_idle_after_abort", busy, 0);
        check("g_flushed", fifo_count, 0);
        check("g_ready_after_abort", desc_ready, 1);
        check("g_no_read_req", mem_read_req, 0);
        check("g_no_write_req", mem_write_req, 0);
        check("g_no_done_now", layer_done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("g_no_done_later", layer_done, 0);
        end
        sq_hold = 1'b0;
        expect_layer(BASE_A, 16'd90, BASE_B, 16'd91, 1, 1'b1, 5);
        push_desc(mk_inst(LT_CONV, 3, 1, 1'b0, 1'b0, 1'b1), 16'd90, 16'd91);
        wait_idle(30, "g_final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        fail("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
